// File: rtl/clock_core_if.sv
// Button, level-control and time-display signals between the clock core and
// its neighbours (debouncers and tick divider upstream, display formatter downstream).
interface clock_core_if;
    logic       tick;
    logic       set;
    logic       left;
    logic       right;
    logic       up;
    logic       down;
    logic       summertime;
    logic       hr12;
    logic       alarm_en;
    logic [4:0] alarm_hr;
    logic [5:0] alarm_min;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic       pm;
    logic       mode;
    logic [1:0] cursor;
    logic       alarm;

    modport master (
        output tick, set, left, right, up, down,
        output summertime, hr12, alarm_en, alarm_hr, alarm_min,
        input  sec, min, hr, pm, mode, cursor, alarm
    );

    modport slave (
        input  tick, set, left, right, up, down,
        input  summertime, hr12, alarm_en, alarm_hr, alarm_min,
        output sec, min, hr, pm, mode, cursor, alarm
    );
endinterface

// File: rtl/clock_core.sv
// Seconds/minutes/hours timekeeping core with RUN/SET modes, cursor-driven
// field editing, 12/24-hour display, summertime offset and minute alarm.
//
// state  | meaning
// -------+---------------------------------------------------------------
// ST_RUN | ticks advance the time, edit buttons ignored
// ST_SET | tick count frozen, up/down edit the field under the cursor
module clock_core #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int TICK_W        = 10
) (
    input  logic         clk,
    input  logic         rst,
    clock_core_if.slave  bus
);

    typedef enum logic {ST_RUN, ST_SET} state_t;

    localparam logic [1:0] CUR_SEC = 2'd0;
    localparam logic [1:0] CUR_MIN = 2'd1;
    localparam logic [1:0] CUR_HR  = 2'd2;

    localparam int              TICK_LAST_INT = TICKS_PER_SEC - 1;
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_LAST_INT[TICK_W-1:0];

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [5:0]        sec_q, sec_d;
    logic [5:0]        min_q, min_d;
    logic [4:0]        hr_q, hr_d;
    logic [1:0]        cursor_q, cursor_d;
    logic              alarm_q, alarm_d;
    logic [4:0]        local_hr;

    function automatic logic [5:0] inc60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] dec60(input logic [5:0] v);
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    function automatic logic [4:0] inc24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [4:0] dec24(input logic [4:0] v);
        return (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    function automatic logic [4:0] to_local(input logic [4:0] h, input logic st);
        return st ? inc24(h) : h;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            tick_cnt_q <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hr_q       <= '0;
            cursor_q   <= CUR_SEC;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            cursor_q   <= cursor_d;
            alarm_q    <= alarm_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hr_d       = hr_q;
        cursor_d   = cursor_q;
        alarm_d    = 1'b0;
        case (state_q)
            ST_RUN: begin
                // i_set takes priority and swallows a coincident tick
                if (bus.set) begin
                    state_d  = ST_SET;
                    cursor_d = CUR_SEC;
                end else if (bus.tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        sec_d      = inc60(sec_q);
                        if (sec_q == 6'd59) begin
                            min_d = inc60(min_q);
                            if (min_q == 6'd59) hr_d = inc24(hr_q);
                        end
                        alarm_d = bus.alarm_en && (sec_d == 6'd0) &&
                                  (min_d == bus.alarm_min) &&
                                  (to_local(hr_d, bus.summertime) == bus.alarm_hr);
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            default: begin
                if (bus.set) begin
                    state_d    = ST_RUN;
                    tick_cnt_d = '0;
                end else begin
                    // edit happens at the old cursor, then the cursor moves
                    if (bus.up ^ bus.down) begin
                        case (cursor_q)
                            CUR_SEC: sec_d = bus.up ? inc60(sec_q) : dec60(sec_q);
                            CUR_MIN: min_d = bus.up ? inc60(min_q) : dec60(min_q);
                            default: hr_d  = bus.up ? inc24(hr_q)  : dec24(hr_q);
                        endcase
                    end
                    if (bus.left ^ bus.right) begin
                        if (bus.left)
                            cursor_d = (cursor_q == CUR_HR) ? CUR_SEC : cursor_q + 2'd1;
                        else
                            cursor_d = (cursor_q == CUR_SEC) ? CUR_HR : cursor_q - 2'd1;
                    end
                end
            end
        endcase
    end

    assign local_hr = to_local(hr_q, bus.summertime);

    always_comb begin
        bus.hr = local_hr;
        bus.pm = 1'b0;
        if (bus.hr12) begin
            bus.pm = (local_hr >= 5'd12);
            if (local_hr == 5'd0)
                bus.hr = 5'd12;
            else if (local_hr > 5'd12)
                bus.hr = local_hr - 5'd12;
        end
    end

    assign bus.sec    = sec_q;
    assign bus.min    = min_q;
    assign bus.mode   = (state_q == ST_SET);
    assign bus.cursor = cursor_q;
    assign bus.alarm  = alarm_q;

endmodule

// File: tb/tb_clock_core.sv
// Directed bench for clock_core at four ticks per second: display mapping
// table plus hand-written rollover, edit, alarm and reset sequences.
module tb_clock_core;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   alarm_cnt = 0;

    clock_core_if bus();

    clock_core #(.TICKS_PER_SEC(4), .TICK_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.alarm === 1'b1) alarm_cnt++;

    // {tick, set, left, right, up, down}
    localparam logic [5:0] B_NONE  = 6'b000000;
    localparam logic [5:0] B_TICK  = 6'b100000;
    localparam logic [5:0] B_SET   = 6'b010000;
    localparam logic [5:0] B_LEFT  = 6'b001000;
    localparam logic [5:0] B_RIGHT = 6'b000100;
    localparam logic [5:0] B_UP    = 6'b000010;
    localparam logic [5:0] B_DOWN  = 6'b000001;

    typedef struct {
        int   hr;
        logic st;
        logic h12;
        int   exp_hr;
        logic exp_pm;
    } disp_vec_t;

    disp_vec_t dv[12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // called at a falling edge; returns at the next falling edge
    task automatic btn(input logic [5:0] v);
        {bus.tick, bus.set, bus.left, bus.right, bus.up, bus.down} = v;
        @(negedge clk);
        {bus.tick, bus.set, bus.left, bus.right, bus.up, bus.down} = B_NONE;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic press_field(input int v, input int range);
        if (v > range / 2) repeat (range - v) btn(B_DOWN);
        else               repeat (v) btn(B_UP);
    endtask

    // starts from 00:00:00 in RUN, leaves RUN with tick count 0
    task automatic set_time(input int h, input int m, input int s);
        btn(B_SET);
        press_field(s, 60);
        btn(B_LEFT);
        press_field(m, 60);
        btn(B_LEFT);
        press_field(h, 24);
        btn(B_SET);
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s);
        check({name, "_hr"},  int'(bus.hr),  h);
        check({name, "_min"}, int'(bus.min), m);
        check({name, "_sec"}, int'(bus.sec), s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected test to end earlier");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        dv[0]  = '{23, 1'b1, 1'b0,  0, 1'b0};
        dv[1]  = '{23, 1'b1, 1'b1, 12, 1'b0};
        dv[2]  = '{12, 1'b0, 1'b1, 12, 1'b1};
        dv[3]  = '{13, 1'b0, 1'b1,  1, 1'b1};
        dv[4]  = '{ 0, 1'b0, 1'b1, 12, 1'b0};
        dv[5]  = '{ 0, 1'b0, 1'b0,  0, 1'b0};
        dv[6]  = '{11, 1'b1, 1'b1, 12, 1'b1};
        dv[7]  = '{11, 1'b1, 1'b0, 12, 1'b0};
        dv[8]  = '{23, 1'b0, 1'b1, 11, 1'b1};
        dv[9]  = '{ 1, 1'b0, 1'b1,  1, 1'b0};
        dv[10] = '{22, 1'b1, 1'b0, 23, 1'b0};
        dv[11] = '{12, 1'b0, 1'b0, 12, 1'b0};

        {bus.tick, bus.set, bus.left, bus.right, bus.up, bus.down} = B_NONE;
        bus.summertime = 1'b0;
        bus.hr12       = 1'b0;
        bus.alarm_en   = 1'b0;
        bus.alarm_hr   = 5'd0;
        bus.alarm_min  = 6'd0;
        @(negedge clk);
        do_reset();

        // reset state
        check_time("rst", 0, 0, 0);
        check("rst_mode",   int'(bus.mode),   0);
        check("rst_cursor", int'(bus.cursor), 0);
        check("rst_alarm",  int'(bus.alarm),  0);
        check("rst_pm",     int'(bus.pm),     0);

        // cursor movement
        btn(B_SET);
        check("set_mode", int'(bus.mode), 1);
        check("set_cursor", int'(bus.cursor), 0);
        btn(B_LEFT);  check("left1", int'(bus.cursor), 1);
        btn(B_LEFT);  check("left2", int'(bus.cursor), 2);
        btn(B_LEFT);  check("left3", int'(bus.cursor), 0);
        btn(B_RIGHT); check("right_wrap", int'(bus.cursor), 2);
        btn(B_LEFT | B_RIGHT); check("left_right", int'(bus.cursor), 2);

        // field edits without carry/borrow
        btn(B_LEFT);
        btn(B_DOWN);
        check("sec_down_wrap", int'(bus.sec), 59);
        check("sec_down_min",  int'(bus.min), 0);
        btn(B_TICK);
        check("set_tick_ignored", int'(bus.sec), 59);
        btn(B_RIGHT); btn(B_RIGHT);
        check("cursor_min", int'(bus.cursor), 1);
        btn(B_DOWN);
        check("min_down_wrap", int'(bus.min), 59);
        btn(B_UP);
        check("min_up_wrap", int'(bus.min), 0);
        check("min_up_hr",   int'(bus.hr),  0);
        btn(B_UP | B_DOWN);
        check("up_down_both", int'(bus.min), 0);
        btn(B_UP | B_LEFT);
        check("up_left_min",    int'(bus.min),    1);
        check("up_left_cursor", int'(bus.cursor), 2);
        check("up_left_hr",     int'(bus.hr),     0);
        btn(B_SET | B_UP);
        check("set_up_mode", int'(bus.mode), 0);
        check("set_up_hr",   int'(bus.hr),   0);
        btn(B_UP);
        check("run_up_ignored", int'(bus.min), 1);
        btn(B_SET | B_TICK);
        check("set_tick_mode", int'(bus.mode), 1);
        btn(B_SET);

        // full rollover at midnight
        do_reset();
        set_time(23, 59, 59);
        check_time("preset", 23, 59, 59);
        repeat (3) btn(B_TICK);
        check_time("three_ticks", 23, 59, 59);
        btn(B_TICK);
        check_time("midnight", 0, 0, 0);

        // display mapping
        for (int i = 0; i < 12; i++) begin
            do_reset();
            set_time(dv[i].hr, 0, 0);
            bus.summertime = dv[i].st;
            bus.hr12       = dv[i].h12;
            #1;
            check($sformatf("disp%0d_hr", i), int'(bus.hr), dv[i].exp_hr);
            check($sformatf("disp%0d_pm", i), int'(bus.pm), int'(dv[i].exp_pm));
            bus.summertime = 1'b0;
            bus.hr12       = 1'b0;
        end

        // alarm fires on tick carry at local 07:30
        bus.alarm_hr   = 5'd7;
        bus.alarm_min  = 6'd30;
        bus.alarm_en   = 1'b1;
        bus.summertime = 1'b1;
        do_reset();
        set_time(6, 29, 59);
        repeat (3) btn(B_TICK);
        c0 = alarm_cnt;
        btn(B_TICK);
        check_time("alarm_time", 7, 30, 0);
        check("alarm_high", int'(bus.alarm), 1);
        @(negedge clk);
        check("alarm_low_next", int'(bus.alarm), 0);
        check("alarm_pulses", alarm_cnt - c0, 1);

        // manual edit to the alarm time does not fire
        do_reset();
        c0 = alarm_cnt;
        set_time(6, 30, 0);
        repeat (3) @(negedge clk);
        check("alarm_manual", alarm_cnt - c0, 0);

        // disabled alarm
        bus.alarm_en = 1'b0;
        do_reset();
        set_time(6, 29, 59);
        c0 = alarm_cnt;
        repeat (4) btn(B_TICK);
        @(negedge clk);
        check("alarm_disabled", alarm_cnt - c0, 0);

        // wrong local hour (no summertime) must not match
        bus.alarm_en   = 1'b1;
        bus.summertime = 1'b0;
        do_reset();
        set_time(6, 29, 59);
        c0 = alarm_cnt;
        repeat (4) btn(B_TICK);
        @(negedge clk);
        check("alarm_wrong_hr", alarm_cnt - c0, 0);
        bus.alarm_en = 1'b0;

        // asynchronous reset mid-second
        do_reset();
        set_time(10, 20, 29);
        repeat (4) btn(B_TICK);
        check_time("pre_reset", 10, 20, 30);
        repeat (2) btn(B_TICK);
        btn(B_SET);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_time("async_rst", 0, 0, 0);
        check("async_rst_mode",   int'(bus.mode),   0);
        check("async_rst_cursor", int'(bus.cursor), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) btn(B_TICK);
        check("post_rst_3ticks", int'(bus.sec), 0);
        btn(B_TICK);
        check("post_rst_4ticks", int'(bus.sec), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
